lut_coeff_loader: RTL and testbench
===================================

Name: lut_coeff_loader

Overview:
- Runtime writer for the interpolation coefficient tables (256 bins x 14 segments = 3584 words per table).
- Takes a valid/ready stream of 32-bit coefficient words, e.g. from host DMA.
- Writes the words table-major into NUM_TABLES single-port coefficient RAMs through their address/data/wren/rden ports.
- Runs before the force-evaluation pipeline starts reading those tables.

Parameters:
- DATA_WIDTH, 32, coefficient word width
- DEPTH, 3584, words per table (256 bins x 14 segments)
- ADDR_WIDTH, 12, table address width
- NUM_TABLES, 4, number of coefficient tables loaded in sequence

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load from IDLE or DONE
- in_data  in  DATA_WIDTH  coefficient word
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a word this cycle
- lut_address  out  ADDR_WIDTH  shared address to all tables
- lut_data  out  DATA_WIDTH  shared write data to all tables
- lut_wren  out  NUM_TABLES  one-hot write enable, one bit per table
- lut_rden  out  1  read enable to all tables
- lut_q  in  NUM_TABLES*DATA_WIDTH  concatenated table outputs; table k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- busy  out  1  load in progress
- done  out  1  high from load completion until the next accepted start
- err  out  1  readback checksum mismatch (only with the optional feature)

Behaviour:
- Reset: asynchronous, active-high. Every output is 0, state is IDLE, all counters and the checksum are 0.
- States: IDLE -> WRITE -> DONE. With the optional feature: IDLE -> WRITE -> VERIFY -> DONE.
- start:
  - In IDLE or DONE: go to WRITE, clear addr_cnt, tbl_cnt, done and err; busy=1 next cycle.
  - In WRITE or VERIFY: ignored.
- WRITE:
  - in_ready=1. A word is accepted when in_valid && in_ready.
  - The cycle after acceptance: lut_address=addr_cnt, lut_data=in_data, lut_wren=(1<<tbl_cnt), then addr_cnt increments. The write reaches the RAM on that registered edge.
  - No accept in a cycle -> lut_wren=0 the next cycle. Address and data hold their last values.
  - Boundary, addr_cnt==DEPTH-1 on accept: addr_cnt wraps to 0 and tbl_cnt increments.
  - Last word (tbl_cnt==NUM_TABLES-1, addr_cnt==DEPTH-1) accepted: in_ready drops the following cycle. The final write is still issued. The state then goes to DONE (or VERIFY).
  - Total words = NUM_TABLES*DEPTH = 14336.
- lut_rden=0 throughout WRITE. It is never 1 in the same cycle as any lut_wren bit.
- DONE: busy=0, done=1, in_ready=0, lut_wren=0.
- Reset mid-load: abort immediately, return to IDLE with done=0. Table contents are left partially written and are not cleaned up.
- Latency, best case (in_valid held high): start at cycle 0 -> first lut_wren at cycle 2 -> done=1 at cycle 14337+1 without verify.

Optional Feature:
- Macro: LUT_LOADER_READBACK_EN.
- When defined:
  - During WRITE, a write-side checksum accumulates the XOR of every accepted word.
  - VERIFY then issues one read per cycle: lut_rden=1 and addresses 0..DEPTH-1 for each table in turn, with tbl_cnt selecting that table's slice of lut_q.
  - RAM read latency is 1 cycle after the registered address. A 2-stage valid/table-index pipeline aligns each lut_q sample with the table it came from; the read-side checksum XORs those samples.
  - VERIFY ends once the pipeline drains after the last sample.
  - err=1 if the read-side and write-side checksums differ, set together with done. VERIFY adds NUM_TABLES*DEPTH+2 cycles.
- When not defined: no VERIFY state, err tied to 0, lut_rden tied to 0, lut_q unused.

Decomposition:
- Shared package/include holds:
  - state encoding constants (S_IDLE, S_WRITE, S_VERIFY, S_DONE);
  - LUT geometry constants: BINS=256, SEGMENTS=14, DEPTH=BINS*SEGMENTS;
  - TOTAL_WORDS=NUM_TABLES*DEPTH.
- One natural sub-module: lut_addr_seq. It is the addr_cnt/tbl_cnt counter pair with an advance input, and wrap and last outputs. WRITE and VERIFY reuse it.

Test Plan:
- Continuous load: in_valid=1, in_data=index. Required response:
  - exactly 14336 lut_wren pulses;
  - lut_wren=4'b0001 at addresses 0..3583, then 4'b0010, and so on;
  - lut_data at table 2, address 5 equals 2*3584+5;
  - done=1 at cycle 14338.
- Wrap and back-pressure: random in_valid gaps around word 3583. Required response:
  - wren goes low in gap cycles;
  - the word after 3583 lands at table 1, address 0, with no skipped or duplicated address.
- start pulsed at word 100 during WRITE -> ignored; counters continue; done follows 14336 total accepts.
- rst asserted at word 5000 -> all outputs 0 asynchronously; a new start restarts at table 0, address 0.
- LUT_LOADER_READBACK_EN with a behavioural RAM model -> err=0, and lut_rden never overlaps lut_wren.
- Same as above, with one bit of table 3, address 100 flipped in the model -> err=1 at done.

Source files
------------

// File: rtl/lut_coeff_loader_pkg.sv
// Shared geometry constants and FSM encoding for the coefficient table loader.
// Readback verification is compiled in when LUT_LOADER_READBACK_EN is defined.
package lut_coeff_loader_pkg;

    localparam int unsigned BINS        = 256;
    localparam int unsigned SEGMENTS    = 14;
    localparam int unsigned DEPTH       = BINS * SEGMENTS;
    localparam int unsigned NUM_TABLES  = 4;
    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned ADDR_WIDTH  = 12;
    localparam int unsigned TOTAL_WORDS = NUM_TABLES * DEPTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_VERIFY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/lut_addr_seq.sv
// Address/table counter pair walked table-major; shared by the write and readback passes.
module lut_addr_seq #(
    parameter int unsigned DEPTH      = lut_coeff_loader_pkg::DEPTH,
    parameter int unsigned ADDR_WIDTH = lut_coeff_loader_pkg::ADDR_WIDTH,
    parameter int unsigned NUM_TABLES = lut_coeff_loader_pkg::NUM_TABLES,
    parameter int unsigned TBL_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_advance,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [TBL_WIDTH-1:0]  o_tbl,
    output logic                  o_wrap_c,
    output logic                  o_last_c
);

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [TBL_WIDTH-1:0]  r_tbl;

    assign o_wrap_c = (r_addr == ADDR_WIDTH'(DEPTH - 1));
    assign o_last_c = o_wrap_c && (r_tbl == TBL_WIDTH'(NUM_TABLES - 1));
    assign o_addr   = r_addr;
    assign o_tbl    = r_tbl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_tbl  <= '0;
        end else if (i_clear) begin
            r_addr <= '0;
            r_tbl  <= '0;
        end else if (i_advance) begin
            if (o_wrap_c) begin
                r_addr <= '0;
                r_tbl  <= o_last_c ? '0 : r_tbl + TBL_WIDTH'(1);
            end else begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/lut_coeff_loader.sv
// Streams coefficient words table-major into NUM_TABLES single-port RAMs.
// Define LUT_LOADER_READBACK_EN to add a checksummed readback pass (VERIFY) before DONE.
module lut_coeff_loader #(
    parameter int unsigned DATA_WIDTH = lut_coeff_loader_pkg::DATA_WIDTH,
    parameter int unsigned DEPTH      = lut_coeff_loader_pkg::DEPTH,
    parameter int unsigned ADDR_WIDTH = lut_coeff_loader_pkg::ADDR_WIDTH,
    parameter int unsigned NUM_TABLES = lut_coeff_loader_pkg::NUM_TABLES
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [ADDR_WIDTH-1:0]            lut_address,
    output logic [DATA_WIDTH-1:0]            lut_data,
    output logic [NUM_TABLES-1:0]            lut_wren,
    output logic                             lut_rden,
    input  logic [NUM_TABLES*DATA_WIDTH-1:0] lut_q,
    output logic                             busy,
    output logic                             done,
    output logic                             err
);
    import lut_coeff_loader_pkg::*;

    localparam int unsigned TBL_WIDTH = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1;

    state_t                r_state, w_state_nxt;
    logic                  r_in_ready, w_in_ready_nxt;
    logic [ADDR_WIDTH-1:0] r_lut_address, w_lut_address_nxt;
    logic [DATA_WIDTH-1:0] r_lut_data, w_lut_data_nxt;
    logic [NUM_TABLES-1:0] r_lut_wren, w_lut_wren_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_write_fin, w_write_fin_nxt;

    logic                  w_accept;
    logic                  w_seq_clear, w_seq_adv;
    logic [ADDR_WIDTH-1:0] w_seq_addr;
    logic [TBL_WIDTH-1:0]  w_seq_tbl;
    logic                  w_unused_wrap;
    logic                  w_seq_last_c;

`ifdef LUT_LOADER_READBACK_EN
    logic                  r_lut_rden, w_lut_rden_nxt;
    logic                  r_err, w_err_nxt;
    logic [DATA_WIDTH-1:0] r_wr_sum, w_wr_sum_nxt;
    logic [DATA_WIDTH-1:0] r_rd_sum, w_rd_sum_nxt;
    logic [DATA_WIDTH-1:0] w_rd_sample;
    logic                  r_rd_fin, w_rd_fin_nxt;
    logic                  r_rd_v1, w_rd_v1_nxt, r_rd_v2;
    logic [TBL_WIDTH-1:0]  r_rd_t1, w_rd_t1_nxt, r_rd_t2;
`endif

    lut_addr_seq #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_TABLES (NUM_TABLES),
        .TBL_WIDTH  (TBL_WIDTH)
    ) u_seq (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_seq_clear),
        .i_advance (w_seq_adv),
        .o_addr    (w_seq_addr),
        .o_tbl     (w_seq_tbl),
        .o_wrap_c  (w_unused_wrap),
        .o_last_c  (w_seq_last_c)
    );

    assign w_accept = in_valid && r_in_ready;

`ifdef LUT_LOADER_READBACK_EN
    // Stage 2 of the read pipeline lines up with lut_q for the table read two cycles earlier.
    assign w_rd_sample = r_rd_v2 ? lut_q[DATA_WIDTH * 32'(r_rd_t2) +: DATA_WIDTH] : '0;
`else
    logic w_unused_q;
    assign w_unused_q = ^lut_q;
`endif

    always_comb begin
        w_state_nxt       = r_state;
        w_in_ready_nxt    = r_in_ready;
        w_lut_address_nxt = r_lut_address;
        w_lut_data_nxt    = r_lut_data;
        w_lut_wren_nxt    = '0;
        w_busy_nxt        = r_busy;
        w_done_nxt        = r_done;
        w_write_fin_nxt   = r_write_fin;
        w_seq_clear       = 1'b0;
        w_seq_adv         = 1'b0;
`ifdef LUT_LOADER_READBACK_EN
        w_lut_rden_nxt    = 1'b0;
        w_err_nxt         = r_err;
        w_wr_sum_nxt      = r_wr_sum;
        w_rd_sum_nxt      = r_rd_sum ^ w_rd_sample;
        w_rd_fin_nxt      = r_rd_fin;
        w_rd_v1_nxt       = 1'b0;
        w_rd_t1_nxt       = r_rd_t1;
`endif
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt     = S_WRITE;
                    w_seq_clear     = 1'b1;
                    w_in_ready_nxt  = 1'b1;
                    w_busy_nxt      = 1'b1;
                    w_done_nxt      = 1'b0;
                    w_write_fin_nxt = 1'b0;
`ifdef LUT_LOADER_READBACK_EN
                    w_err_nxt       = 1'b0;
                    w_wr_sum_nxt    = '0;
`endif
                end
            end
            S_WRITE: begin
                // r_write_fin marks the cycle the final write is on the RAM ports.
                if (r_write_fin) begin
`ifdef LUT_LOADER_READBACK_EN
                    w_state_nxt  = S_VERIFY;
                    w_seq_clear  = 1'b1;
                    w_rd_sum_nxt = '0;
                    w_rd_fin_nxt = 1'b0;
`else
                    w_state_nxt  = S_DONE;
                    w_busy_nxt   = 1'b0;
                    w_done_nxt   = 1'b1;
`endif
                end else if (w_accept) begin
                    w_lut_address_nxt = w_seq_addr;
                    w_lut_data_nxt    = in_data;
                    w_lut_wren_nxt    = NUM_TABLES'(1) << w_seq_tbl;
                    w_seq_adv         = 1'b1;
`ifdef LUT_LOADER_READBACK_EN
                    w_wr_sum_nxt      = r_wr_sum ^ in_data;
`endif
                    if (w_seq_last_c) begin
                        w_in_ready_nxt  = 1'b0;
                        w_write_fin_nxt = 1'b1;
                    end
                end
            end
`ifdef LUT_LOADER_READBACK_EN
            S_VERIFY: begin
                if (!r_rd_fin) begin
                    w_lut_rden_nxt    = 1'b1;
                    w_lut_address_nxt = w_seq_addr;
                    w_seq_adv         = 1'b1;
                    w_rd_v1_nxt       = 1'b1;
                    w_rd_t1_nxt       = w_seq_tbl;
                    w_rd_fin_nxt      = w_seq_last_c;
                end
                // Leave once the last sample is folded in this cycle.
                if (r_rd_fin && !r_rd_v1 && r_rd_v2) begin
                    w_state_nxt = S_DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = (w_rd_sum_nxt != r_wr_sum);
                end
            end
`endif
            default: begin
                w_state_nxt    = S_IDLE;
                w_in_ready_nxt = 1'b0;
                w_busy_nxt     = 1'b0;
                w_done_nxt     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_in_ready    <= 1'b0;
            r_lut_address <= '0;
            r_lut_data    <= '0;
            r_lut_wren    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_write_fin   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_in_ready    <= w_in_ready_nxt;
            r_lut_address <= w_lut_address_nxt;
            r_lut_data    <= w_lut_data_nxt;
            r_lut_wren    <= w_lut_wren_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_write_fin   <= w_write_fin_nxt;
        end
    end

`ifdef LUT_LOADER_READBACK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lut_rden <= 1'b0;
            r_err      <= 1'b0;
            r_wr_sum   <= '0;
            r_rd_sum   <= '0;
            r_rd_fin   <= 1'b0;
            r_rd_v1    <= 1'b0;
            r_rd_v2    <= 1'b0;
            r_rd_t1    <= '0;
            r_rd_t2    <= '0;
        end else begin
            r_lut_rden <= w_lut_rden_nxt;
            r_err      <= w_err_nxt;
            r_wr_sum   <= w_wr_sum_nxt;
            r_rd_sum   <= w_rd_sum_nxt;
            r_rd_fin   <= w_rd_fin_nxt;
            r_rd_v1    <= w_rd_v1_nxt;
            r_rd_v2    <= r_rd_v1;
            r_rd_t1    <= w_rd_t1_nxt;
            r_rd_t2    <= r_rd_t1;
        end
    end

    assign lut_rden = r_lut_rden;
    assign err      = r_err;
`else
    assign lut_rden = 1'b0;
    assign err      = 1'b0;
`endif

    assign in_ready    = r_in_ready;
    assign lut_address = r_lut_address;
    assign lut_data    = r_lut_data;
    assign lut_wren    = r_lut_wren;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_lut_coeff_loader.sv
// Self-checking bench for lut_coeff_loader with a behavioural RAM model.
// Readback scenarios are active when LUT_LOADER_READBACK_EN is defined.
`timescale 1ns/1ps
module tb_lut_coeff_loader;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 3584;
    localparam int unsigned AW    = 12;
    localparam int unsigned NT    = 4;
    localparam int unsigned TOTAL = NT * DEPTH;
`ifdef LUT_LOADER_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    // Write pass ends at TOTAL+2; readback appends TOTAL+2 more cycles.
    localparam int DONE_CYC = int'(TOTAL) + 2 + (RB ? int'(TOTAL) + 2 : 0);

    logic            clk;
    logic            rst;
    logic            start;
    logic [DW-1:0]   in_data;
    logic            in_valid;
    logic            in_ready;
    logic [AW-1:0]   lut_address;
    logic [DW-1:0]   lut_data;
    logic [NT-1:0]   lut_wren;
    logic            lut_rden;
    logic [NT*DW-1:0] lut_q;
    logic            busy;
    logic            done;
    logic            err;

    lut_coeff_loader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .lut_address (lut_address),
        .lut_data    (lut_data),
        .lut_wren    (lut_wren),
        .lut_rden    (lut_rden),
        .lut_q       (lut_q),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAMs, one-cycle read latency, optional bit flip on readout.
    logic [DW-1:0] ram [NT][DEPTH];
    bit            corrupt;
    initial lut_q = '0;
    always @(posedge clk) begin
        for (int k = 0; k < int'(NT); k++) begin
            if (lut_wren[k] && lut_address < AW'(DEPTH)) ram[k][lut_address] <= lut_data;
            if (lut_rden && lut_address < AW'(DEPTH))
                lut_q[k*DW +: DW] <= ram[k][lut_address] ^
                    ((corrupt && k == int'(NT) - 1 && lut_address == AW'(100)) ? 32'h0000_0010 : 32'h0);
        end
    end

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] sent [TOTAL];
    int cyc, accepted, n_writes, n_place_bad, n_gap_bad, n_overlap, n_rden;
    int first_wren, done_cyc;
    bit busy_c1, done_c1, fin_busy, fin_inready, fin_err, timed_out;

    // Drives one load from a start pulse and tracks every write against the expected placement:
    // the i-th accepted word must land at table i/DEPTH, address i%DEPTH, the cycle after acceptance.
    task automatic run_load(input bit idx_data, input bit gaps, input int pulse_at, input int reset_at);
        bit prev_acc   = 1'b0;
        bit pulsed     = 1'b0;
        int gap_cycles = 0;
        int t, a;
        accepted = 0; n_writes = 0; n_place_bad = 0; n_gap_bad = 0; n_overlap = 0; n_rden = 0;
        first_wren = -1; done_cyc = -1; timed_out = 1'b0;
        busy_c1 = 1'b0; done_c1 = 1'b0; fin_busy = 1'b0; fin_inready = 1'b0; fin_err = 1'b0;
        @(posedge clk); #1;
        cyc = 0; start = 1'b1; in_valid = 1'b1;
        in_data = idx_data ? 32'd0 : $urandom;
        forever begin
            @(negedge clk);
            if (lut_rden) n_rden++;
            if (lut_rden && lut_wren != '0) n_overlap++;
            if (lut_wren != '0) begin
                t = n_writes / int'(DEPTH);
                a = n_writes % int'(DEPTH);
                if (first_wren < 0) first_wren = cyc;
                if (!prev_acc) n_gap_bad++;
                if (n_writes >= int'(TOTAL) || lut_wren !== NT'(1 << t) ||
                    lut_address !== AW'(a) || lut_data !== sent[n_writes]) n_place_bad++;
                n_writes++;
            end else if (prev_acc) begin
                n_gap_bad++;
            end
            if (cyc == 1) begin busy_c1 = busy; done_c1 = done; end
            if (done && cyc > 0) begin
                done_cyc = cyc; fin_busy = busy; fin_inready = in_ready; fin_err = err;
                break;
            end
            prev_acc = in_valid && in_ready;
            if (prev_acc) begin
                if (accepted < int'(TOTAL)) sent[accepted] = in_data;
                accepted++;
            end
            if (reset_at >= 0 && accepted >= reset_at) break;
            if (cyc >= 40000) begin timed_out = 1'b1; break; end
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (pulse_at >= 0 && !pulsed && accepted == pulse_at) begin start = 1'b1; pulsed = 1'b1; end
            in_valid = 1'b1;
            if (gaps && accepted == int'(DEPTH) && gap_cycles < 3) begin
                in_valid = 1'b0; gap_cycles++;
            end else if (gaps && accepted >= int'(DEPTH) - 14 && accepted < int'(DEPTH) + 16) begin
                in_valid = ($urandom_range(0, 2) != 0);
            end
            if (idx_data) in_data = 32'(accepted);
            else if (prev_acc) in_data = $urandom;
        end
        start = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, lut_address, lut_data, lut_wren, lut_rden, busy, done, err} !== 53'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {in_ready, lut_address, lut_data, lut_wren, lut_rden, busy, done, err});
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b1; in_data = $urandom;
        repeat (4) begin
            @(negedge clk);
            if (in_ready || lut_wren != '0 || busy || done) bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle_without_start: got %0d active cycles required 0", bad);
        end
    endtask

    task automatic test_continuous();
        run_load(1'b1, 1'b0, 100, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL cont_timeout: got 1 required 0"); end
        checks++; if (first_wren !== 2) begin errors++; $display("FAIL cont_first_wren: got cycle %0d required 2", first_wren); end
        checks++; if (done_cyc !== DONE_CYC) begin errors++; $display("FAIL cont_done_cycle: got %0d required %0d", done_cyc, DONE_CYC); end
        checks++; if (n_writes !== int'(TOTAL)) begin errors++; $display("FAIL cont_write_count: got %0d required %0d", n_writes, TOTAL); end
        checks++; if (accepted !== int'(TOTAL)) begin errors++; $display("FAIL cont_accepts: got %0d required %0d", accepted, TOTAL); end
        checks++; if (n_place_bad !== 0) begin errors++; $display("FAIL cont_placement: got %0d bad writes required 0", n_place_bad); end
        checks++; if (n_gap_bad !== 0) begin errors++; $display("FAIL cont_wren_timing: got %0d bad cycles required 0", n_gap_bad); end
        checks++; if (ram[2][5] !== 32'(2 * DEPTH + 5)) begin errors++; $display("FAIL cont_t2_a5: got %0d required %0d", ram[2][5], 2 * DEPTH + 5); end
        checks++; if (ram[3][DEPTH-1] !== 32'(TOTAL - 1)) begin errors++; $display("FAIL cont_last_word: got %0d required %0d", ram[3][DEPTH-1], TOTAL - 1); end
        checks++; if (n_overlap !== 0) begin errors++; $display("FAIL cont_rden_wren_overlap: got %0d required 0", n_overlap); end
        checks++; if (n_rden !== (RB ? int'(TOTAL) : 0)) begin errors++; $display("FAIL cont_read_count: got %0d required %0d", n_rden, RB ? TOTAL : 0); end
        checks++; if (fin_err !== 1'b0) begin errors++; $display("FAIL cont_err: got %0b required 0", fin_err); end
        checks++; if ({fin_busy, fin_inready} !== 2'b00) begin errors++; $display("FAIL cont_done_state: got busy/ready %b required 00", {fin_busy, fin_inready}); end
        checks++; if ({busy_c1, done_c1} !== 2'b10) begin errors++; $display("FAIL cont_start_response: got busy/done %b required 10", {busy_c1, done_c1}); end
        repeat (3) @(negedge clk);
        checks++; if ({done, busy, lut_wren} !== {2'b10, 4'b0000}) begin errors++; $display("FAIL cont_done_hold: got %b required 100000", {done, busy, lut_wren}); end
    endtask

    task automatic test_wrap_backpressure_and_reset();
        run_load(1'b0, 1'b1, -1, 5000);
        // Assert reset mid-cycle: outputs must clear with no clock edge.
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, lut_address, lut_data, lut_wren, lut_rden, busy, done, err} !== 53'd0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %h required 0",
                     {in_ready, lut_address, lut_data, lut_wren, lut_rden, busy, done, err});
        end
        checks++; if ({busy_c1, done_c1} !== 2'b10) begin errors++; $display("FAIL restart_from_done: got busy/done %b required 10", {busy_c1, done_c1}); end
        checks++; if (timed_out) begin errors++; $display("FAIL wrap_timeout: got 1 required 0"); end
        checks++; if (n_gap_bad !== 0) begin errors++; $display("FAIL wrap_wren_gaps: got %0d bad cycles required 0", n_gap_bad); end
        checks++; if (n_place_bad !== 0) begin errors++; $display("FAIL wrap_placement: got %0d bad writes required 0", n_place_bad); end
        checks++; if (n_writes !== accepted - 1) begin errors++; $display("FAIL wrap_write_count: got %0d required %0d", n_writes, accepted - 1); end
        checks++; if (ram[1][0] !== sent[DEPTH]) begin errors++; $display("FAIL wrap_t1_a0: got %h required %h", ram[1][0], sent[DEPTH]); end
        checks++; if (ram[0][DEPTH-1] !== sent[DEPTH-1]) begin errors++; $display("FAIL wrap_t0_last: got %h required %h", ram[0][DEPTH-1], sent[DEPTH-1]); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({busy, done, in_ready} !== 3'b000) begin errors++; $display("FAIL post_reset_idle: got %b required 000", {busy, done, in_ready}); end
    endtask

    task automatic test_restart_readback();
        corrupt = RB;
        run_load(1'b0, 1'b0, -1, -1);
        corrupt = 1'b0;
        checks++; if (timed_out) begin errors++; $display("FAIL restart_timeout: got 1 required 0"); end
        checks++; if (first_wren !== 2) begin errors++; $display("FAIL restart_first_wren: got cycle %0d required 2", first_wren); end
        checks++; if (n_place_bad !== 0) begin errors++; $display("FAIL restart_placement: got %0d bad writes required 0", n_place_bad); end
        checks++; if (done_cyc !== DONE_CYC) begin errors++; $display("FAIL restart_done_cycle: got %0d required %0d", done_cyc, DONE_CYC); end
        checks++; if (accepted !== int'(TOTAL)) begin errors++; $display("FAIL restart_accepts: got %0d required %0d", accepted, TOTAL); end
        checks++; if (n_overlap !== 0) begin errors++; $display("FAIL restart_rden_wren_overlap: got %0d required 0", n_overlap); end
        checks++; if (fin_err !== RB) begin errors++; $display("FAIL restart_err: got %0b required %0b", fin_err, RB); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; corrupt = 1'b0;
        test_reset();
        test_continuous();
        test_wrap_backpressure_and_reset();
        test_restart_readback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
